// File: rtl/controller_digit_entry_if.sv
//------------------------------------------------------------------------------
// controller_digit_entry_if
// Key-event input channel, committed-number output channel and live entry
// display signals of the calculator digit-entry controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface controller_digit_entry_if #(
  parameter int DIGITS = 8
);
  // key event channel
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_kind;
  logic [3:0]            in_digit;
  // committed number channel
  logic                  num_valid;
  logic                  num_ready;
  logic [4*DIGITS-1:0]   num_bcd;
  logic                  num_neg;
  // live entry display
  logic [4*DIGITS-1:0]   entry_bcd;
  logic                  entry_neg;
  logic [3:0]            entry_cnt;
  logic                  overflow;

  // driver of key events / consumer of committed numbers
  modport master (
    output in_valid, in_kind, in_digit, num_ready,
    input  in_ready, num_valid, num_bcd, num_neg,
    input  entry_bcd, entry_neg, entry_cnt, overflow
  );

  // the digit-entry controller itself
  modport slave (
    input  in_valid, in_kind, in_digit, num_ready,
    output in_ready, num_valid, num_bcd, num_neg,
    output entry_bcd, entry_neg, entry_cnt, overflow
  );
endinterface

`default_nettype wire

// File: rtl/controller_digit_entry.sv
//------------------------------------------------------------------------------
// controller_digit_entry
// Collects BCD key events into a left-shifting entry buffer with sign and
// overflow tracking, and hands the committed number downstream through a
// valid/ready handshake.
// Optional feature: define CALC_BACKSPACE_EN to enable the BACK key
// (shift right, zero fill). Without it BACK is ignored like a reserved code.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module controller_digit_entry #(
  parameter int DIGITS = 8
) (
  input  wire                       clk_i,
  input  wire                       rst_ni,
  controller_digit_entry_if.slave   bus
);

  localparam int           c_W       = 4 * DIGITS;
  localparam logic [3:0]   c_FULL    = 4'(DIGITS);
  localparam logic [2:0]   c_K_DIGIT = 3'd0;
  localparam logic [2:0]   c_K_SIGN  = 3'd1;
`ifdef CALC_BACKSPACE_EN
  localparam logic [2:0]   c_K_BACK  = 3'd2;
`endif
  localparam logic [2:0]   c_K_CLEAR = 3'd3;
  localparam logic [2:0]   c_K_COMMIT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [c_W-1:0]   buf_q, buf_d;
  logic             neg_q, neg_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [c_W-1:0]   num_bcd_q, num_bcd_d;
  logic             num_neg_q, num_neg_d;
  logic             num_valid_q, num_valid_d;
  logic             w_ready;

  // Key events are refused only while a committed number is waiting downstream.
  assign w_ready = (state_q != ST_HOLD);

  // State and datapath registers, all cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= 4'd0;
      ovf_q       <= 1'b0;
      num_bcd_q   <= '0;
      num_neg_q   <= 1'b0;
      num_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      num_bcd_q   <= num_bcd_d;
      num_neg_q   <= num_neg_d;
      num_valid_q <= num_valid_d;
    end
  end

  // Next-state logic: key decoding while entering, handshake while holding.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    num_bcd_d   = num_bcd_q;
    num_neg_d   = num_neg_q;
    num_valid_d = num_valid_q;

    if (state_q == ST_HOLD) begin
      // Accepted number leaves; the entry starts afresh.
      if (num_valid_q && bus.num_ready) begin
        state_d     = ST_IDLE;
        buf_d       = '0;
        neg_d       = 1'b0;
        cnt_d       = 4'd0;
        ovf_d       = 1'b0;
        num_valid_d = 1'b0;
      end
    end else if (bus.in_valid) begin
      case (bus.in_kind)
        c_K_DIGIT: begin
          if (bus.in_digit <= 4'd9) begin
            if (cnt_q == c_FULL) begin
              ovf_d = 1'b1;
            end else if (!(bus.in_digit == 4'd0 && cnt_q == 4'd0)) begin
              // Leading zeros are never stored.
              buf_d   = (buf_q << 4) | c_W'(bus.in_digit);
              cnt_d   = cnt_q + 4'd1;
              state_d = ST_ENTRY;
            end
          end
        end
        c_K_SIGN: begin
          neg_d   = ~neg_q;
          state_d = ST_ENTRY;
        end
`ifdef CALC_BACKSPACE_EN
        c_K_BACK: begin
          ovf_d = 1'b0;
          if (cnt_q != 4'd0) begin
            buf_d = buf_q >> 4;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && !neg_q) begin
              state_d = ST_IDLE;
            end
          end
        end
`endif
        c_K_CLEAR: begin
          state_d = ST_IDLE;
          buf_d   = '0;
          neg_d   = 1'b0;
          cnt_d   = 4'd0;
          ovf_d   = 1'b0;
        end
        c_K_COMMIT: begin
          // A zero magnitude is always presented as +0.
          num_bcd_d   = buf_q;
          num_neg_d   = neg_q & (|buf_q);
          num_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.num_valid = num_valid_q;
  assign bus.num_bcd   = num_bcd_q;
  assign bus.num_neg   = num_neg_q;
  assign bus.entry_bcd = buf_q;
  assign bus.entry_neg = neg_q;
  assign bus.entry_cnt = cnt_q;
  assign bus.overflow  = ovf_q;

endmodule

`default_nettype wire

// File: doc/controller_digit_entry.md
CONTROLLER_DIGIT_ENTRY -- requirements
Module: controller_digit_entry

Interface
REQ-001 Parameter DIGITS, default 8, the number of BCD digits held in the entry buffer; legal range 1..15.
REQ-002 Port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port Reset, input, 1, asynchronous active-low reset.
REQ-004 Port in_valid, input, 1, a key event is presented.
REQ-005 Port in_ready, output, 1, the block accepts a key event this cycle.
REQ-006 Port in_kind, input, 3, event code: 0 DIGIT, 1 SIGN, 2 BACK, 3 CLEAR, 4 COMMIT, 5-7 reserved.
REQ-007 Port in_digit, input, 4, digit value; used only for DIGIT.
REQ-008 Port num_valid, output, 1, a committed number is presented downstream to the number register stage.
REQ-009 Port num_ready, input, 1, downstream accepts the committed number.
REQ-010 Port num_bcd, output, 4*DIGITS, committed magnitude, packed BCD, least significant digit in bits [3:0].
REQ-011 Port num_neg, output, 1, committed sign; 1 means negative.
REQ-012 Port entry_bcd, output, 4*DIGITS, live entry buffer for display.
REQ-013 Port entry_neg, output, 1, live sign.
REQ-014 Port entry_cnt, output, 4, number of significant digits in the buffer, 0..DIGITS.
REQ-015 Port overflow, output, 1, sticky flag: a digit was dropped because the buffer was full.

Function
REQ-016 The FSM SHALL have three states: IDLE (count 0), ENTRY (count >= 1 or sign set), and HOLD (a committed number is pending).
REQ-017 in_ready SHALL be 1 in IDLE and ENTRY and 0 in HOLD; an event is accepted only when in_valid and in_ready are both 1.
REQ-018 An accepted DIGIT with value 0..9 SHALL shift the buffer left by 4 bits, insert the digit at [3:0], and increment the count, taking effect next cycle.
REQ-019 An accepted DIGIT of 0 while the count is 0 SHALL leave the buffer and count unchanged, so no leading zeros are stored.
REQ-020 An accepted DIGIT while the count equals DIGITS SHALL leave the buffer unchanged and set overflow.
REQ-021 An accepted DIGIT with value 10..15 SHALL be ignored.
REQ-022 An accepted SIGN SHALL toggle entry_neg and move the FSM to ENTRY.
REQ-023 BACK SHALL be handled as defined under Configuration.
REQ-024 An accepted CLEAR SHALL zero the buffer, count, sign and overflow, and return the FSM to IDLE.
REQ-025 An accepted COMMIT SHALL copy the buffer to num_bcd and the sign to num_neg, assert num_valid on the next cycle, and move the FSM to HOLD; COMMIT from IDLE commits the value +0.
REQ-026 A committed zero magnitude SHALL always present num_neg=0.
REQ-027 Accepted reserved codes SHALL have no effect.
REQ-028 In HOLD, num_valid, num_bcd and num_neg SHALL remain stable until num_ready is 1.
REQ-029 When num_valid and num_ready are both 1, the FSM SHALL go to IDLE with the buffer, sign, count and overflow cleared, num_valid SHALL be 0 on the next cycle, and in_ready SHALL be 1 on the next cycle.
REQ-030 The transition to ENTRY SHALL occur on the first stored digit or on SIGN; the FSM SHALL return to IDLE when BACK leaves count 0 with the sign clear.

Reset
REQ-031 When Reset=0, asynchronously and irrespective of the current state, the block SHALL clear all registers: FSM to IDLE, buffers zero, signs 0, count 0, overflow 0, num_valid 0.
REQ-032 A pending committed number is discarded by reset, and in_ready SHALL be 1 in the first cycle after Reset is released.

Configuration
REQ-033 With CALC_BACKSPACE_EN defined, an accepted BACK SHALL shift the buffer right by 4 bits with zero fill and decrement the count; at count 0 it SHALL have no effect; it SHALL also clear overflow.
REQ-034 Without CALC_BACKSPACE_EN, BACK SHALL be treated as a reserved code with no effect, and the shift-right logic SHALL be absent.

Verification
REQ-035 Sequence DIGIT 1, DIGIT 2, DIGIT 3, COMMIT, with num_ready=1 -> num_bcd=0x00000123 and num_neg=0 for exactly one cycle, then IDLE.
REQ-036 Sequence DIGIT 0, DIGIT 0, DIGIT 5 -> entry_bcd=0x00000005 and entry_cnt=1.
REQ-037 Nine DIGIT 9 events with DIGITS=8 -> entry_bcd=0x99999999, entry_cnt=8, overflow=1; CLEAR -> all zero.
REQ-038 Sequence DIGIT 7, SIGN, COMMIT, holding num_ready=0 for 5 cycles -> num_valid=1 stable with num_bcd=0x7 and num_neg=1, and in_ready=0 throughout; num_ready=1 -> handshake, then in_ready=1 on the next cycle.
REQ-039 With CALC_BACKSPACE_EN: sequence DIGIT 4, DIGIT 2, BACK -> entry_bcd=0x4 and entry_cnt=1; BACK, BACK -> count 0 and FSM in IDLE. Without the macro, the same sequence -> entry_bcd=0x42.
REQ-040 Reset asserted while in HOLD -> num_valid=0 immediately (asynchronously) and all outputs zero; SIGN then COMMIT -> num_neg=0 and num_bcd=0.
